im_prefetch_buffer: RTL
=======================

Name: im_prefetch_buffer

Overview:
- Sequential instruction prefetcher between the core's instruction-memory port (cache refill request/address/ready/data) and the external instruction memory.
- Serves sequential fetches from a small FIFO of prefetched words; any non-sequential address flushes the FIFO and restarts prefetching at that address.
- Hides memory latency for straight-line code feeding the IF stage's instruction cache.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-low
- i_cpu_req  input  1  core fetch request; held until o_cpu_ready
- i_cpu_addr  input  XLEN  requested word address; stable while i_cpu_req
- o_cpu_ready  output  1  one-cycle pulse: o_cpu_data valid for the current request
- o_cpu_data  output  XLEN  returned instruction word
- i_flush  input  1  invalidate buffer (fence.i / trap redirect)
- o_mem_req  output  1  memory read request; held until i_mem_ack
- o_mem_addr  output  XLEN  memory read address; stable while o_mem_req
- i_mem_data  input  XLEN  read data, valid in the i_mem_ack cycle
- i_mem_ack  input  1  memory completion
- o_count  output  $clog2(DEPTH)+1  valid entries (debug/perf)

Behaviour:
- Reset (i_rst=0 at posedge): o_cpu_ready=0, o_cpu_data=0, o_mem_req=0, o_mem_addr=0, o_count=0; base_valid=0, stale=0. An outstanding memory request is abandoned.
- State: FIFO (head ptr, tail ptr, count), head_addr (address of the head entry), fetch_addr (next address to prefetch), base_valid, mem FSM {IDLE, BUSY}, stale flag.
- Evaluation cycle: i_cpu_req=1 and o_cpu_ready=0. While o_cpu_ready=1, i_cpu_req is ignored, so a request is never served twice.
- Hit: evaluation with count!=0 and i_cpu_addr==head_addr.
  - Next cycle: o_cpu_ready=1, o_cpu_data=head word.
  - Pop head; head_addr += 4.
- Miss: evaluation without a hit.
  - count<=0; head_addr<=i_cpu_addr; fetch_addr<=i_cpu_addr; base_valid<=1.
  - If the FSM is BUSY, stale<=1.
- Issue: FSM IDLE, base_valid=1, and count + pending < DEPTH, where pending = BUSY. Next cycle: o_mem_req=1, o_mem_addr=fetch_addr, FSM=BUSY, fetch_addr += 4.
- Ack (BUSY and i_mem_ack):
  - FSM -> IDLE; o_mem_req drops next cycle.
  - If stale: discard the data and clear stale.
  - Otherwise push i_mem_data at the tail.
  - A new issue may be decided in the ack cycle (back-to-back requests).
- o_mem_addr never changes while o_mem_req=1; a miss during BUSY only marks the in-flight request stale.
- Address arithmetic is modulo 2^XLEN: 0xFFFF_FFFC + 4 = 0x0000_0000. addr[1:0] are carried unchanged (misaligned PCs are trapped by the core, not here).
- Full: count==DEPTH, or count==DEPTH-1 with a request BUSY, stops issue. Pop and push in the same cycle leave count unchanged.
- i_flush=1: count<=0; base_valid<=0; stale<=1 if BUSY. The evaluation in the same cycle is suppressed and re-evaluated next cycle, where it misses. Flush beats push and hit.
- Latency, memory acking 1 cycle after req:
  - Hit: ready 1 cycle after evaluation.
  - Cold miss at cycle t: o_mem_req at t+1, ack at t+2, push, hit evaluation at t+3, ready at t+4.

Optional Feature:
- Macro: ARVI_PREFETCH_BYPASS_EN.
- Defined: if a non-stale ack arrives with count==0, a pending evaluation-eligible i_cpu_req and i_cpu_addr==head_addr, the data goes straight to o_cpu_data with o_cpu_ready=1 next cycle. That word is not pushed; head_addr += 4. Cold-miss ready moves to t+3.
- Undefined: ack data is always pushed and served through the normal hit path.

Test Plan:
- Reset, then req 0x100; mem acks 1 cycle after each req -> o_mem_req addrs 0x100,0x104,0x108,0x10C; ready at t+4 with word@0x100; o_count saturates at 4 minus pops; no 5th issue while full.
- Sequential 0x100..0x11C once buffer warm -> each request ready exactly 1 cycle after evaluation; data matches memory model.
- Jump to 0x400 while a prefetch of 0x110 is in flight -> 0x110 ack discarded; next o_mem_addr=0x400; ready returns word@0x400, never word@0x110.
- Start at 0xFFFF_FFF8 -> prefetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4; sequential requests hit across the wrap.
- i_flush pulsed with count=3 and req 0x108 pending -> o_count=0; 0x108 re-fetched from memory; o_mem_req held stable through the flush until ack.
- Reset asserted while o_mem_req=1 and count=2 -> next cycle all outputs 0; no issue until a new i_cpu_req; with ARVI_PREFETCH_BYPASS_EN the cold miss returns at t+3.

Source files
------------

// File: rtl/im_prefetch_buffer.sv
// im_prefetch_buffer: sequential instruction prefetcher between the core's
// instruction-fetch port and external instruction memory. Serves straight-line
// fetches from a small FIFO; a non-sequential address restarts prefetching.
// Optional build macro: ARVI_PREFETCH_BYPASS_EN forwards an ack word straight
// to the core when it is exactly the word the core is waiting on.
module im_prefetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cpu_req,
  input  logic [XLEN-1:0]          i_cpu_addr,
  output logic                     o_cpu_ready,
  output logic [XLEN-1:0]          o_cpu_data,
  input  logic                     i_flush,
  output logic                     o_mem_req,
  output logic [XLEN-1:0]          o_mem_addr,
  input  logic [XLEN-1:0]          i_mem_data,
  input  logic                     i_mem_ack,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  typedef enum logic {IDLE, BUSY} mem_state_t;

  mem_state_t      state;
  logic [XLEN-1:0] fifo [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [XLEN-1:0] head_addr;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] issue_addr;
  logic            base_valid;
  logic            stale;

  logic eval, addr_match, hit, miss, ack, good_ack, bypass, push, pop, can_issue;

  assign o_count = count;

  // Request classification, FIFO occupancy update and issue decision.
  always_comb begin
    eval       = i_cpu_req & ~o_cpu_ready & ~i_flush;
    addr_match = base_valid & (i_cpu_addr == head_addr);
    hit        = eval & (count != '0) & addr_match;
    // An empty buffer whose stream already targets the requested address is
    // waiting for data, not missing; re-missing would stale its own fetch.
    miss       = eval & ~addr_match;
    ack        = (state == BUSY) & i_mem_ack;
    // Ack data belongs to the live stream only if no redirect lands this cycle.
    good_ack   = ack & ~stale & ~miss & ~i_flush;
`ifdef ARVI_PREFETCH_BYPASS_EN
    bypass     = good_ack & eval & addr_match & (count == '0);
`else
    bypass     = 1'b0;
`endif
    push       = good_ack & ~bypass;
    pop        = hit;

    count_next = count;
    if (i_flush || miss)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);

    issue_addr = miss ? i_cpu_addr : fetch_addr;
    can_issue  = ((state == IDLE) | ack) & ~i_flush & (miss | base_valid) &
                 (count_next < CW'(DEPTH));
  end

  // FIFO storage: written on push, contents need no reset.
  always_ff @(posedge i_clk) begin
    if (push)
      fifo[tail] <= i_mem_data;
  end

  // Buffer control, core response and memory request FSM.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_cpu_ready <= 1'b0;
      o_cpu_data  <= '0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      head_addr   <= '0;
      fetch_addr  <= '0;
      base_valid  <= 1'b0;
      stale       <= 1'b0;
    end else begin
      o_cpu_ready <= hit | bypass;
      if (hit)
        o_cpu_data <= fifo[head];
      else if (bypass)
        o_cpu_data <= i_mem_data;

      count <= count_next;
      if (i_flush || miss) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (pop)
          head <= head + PW'(1);
        if (push)
          tail <= tail + PW'(1);
      end

      if (miss)
        head_addr <= i_cpu_addr;
      else if (hit || bypass)
        head_addr <= head_addr + STEP;

      if (i_flush)
        base_valid <= 1'b0;
      else if (miss)
        base_valid <= 1'b1;

      // Only a request still in flight after this cycle can return stale data.
      if ((i_flush || miss) && state == BUSY && !i_mem_ack)
        stale <= 1'b1;
      else if (ack)
        stale <= 1'b0;

      if (can_issue)
        fetch_addr <= issue_addr + STEP;
      else if (miss)
        fetch_addr <= i_cpu_addr;

      if (can_issue) begin
        o_mem_req  <= 1'b1;
        o_mem_addr <= issue_addr;
        state      <= BUSY;
      end else if (ack) begin
        o_mem_req  <= 1'b0;
        state      <= IDLE;
      end
    end
  end

endmodule
